// File: rtl/mem_rr_arb.sv
// Two-requester round-robin arbiter sharing one memory port, with address-window error check.
// Define MEM_ARB_HOLD_EN to let the current owner keep priority for up to HOLD_MAX consecutive accepts.
module mem_rr_arb #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0001_0000,
  parameter int          HOLD_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s0_cs,
  input  logic        s0_we,
  input  logic [31:0] s0_addr,
  input  logic [3:0]  s0_byte,
  input  logic [31:0] s0_di,
  output logic [31:0] s0_do,
  output logic        s0_busy,
  output logic        s0_err,
  input  logic        s1_cs,
  input  logic        s1_we,
  input  logic [31:0] s1_addr,
  input  logic [3:0]  s1_byte,
  input  logic [31:0] s1_di,
  output logic [31:0] s1_do,
  output logic        s1_busy,
  output logic        s1_err,
  output logic        m_cs,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_byte,
  output logic [31:0] m_di,
  input  logic [31:0] m_do,
  input  logic        m_busy
);

  logic        rr_ptr_q, rr_ptr_d;
  logic        rd_vld_q, rd_vld_d;
  logic        rd_own_q, rd_own_d;
  logic        err0_q, err0_d;
  logic        err1_q, err1_d;
  logic [31:0] hold0_q, hold0_d;
  logic [31:0] hold1_q, hold1_d;

  logic in_rng0, in_rng1;
  logic vld0, vld1;
  logic win;
  logic acc;

`ifdef MEM_ARB_HOLD_EN
  localparam logic [2:0] HOLD_LIM = 3'(HOLD_MAX);
  logic [2:0] hold_cnt_q, hold_cnt_d;
  logic       keep;
`endif

  always_comb begin
    in_rng0 = (ADDR_SIZE == 32'd0) || ((s0_addr - ADDR_BASE) < ADDR_SIZE);
    in_rng1 = (ADDR_SIZE == 32'd0) || ((s1_addr - ADDR_BASE) < ADDR_SIZE);
    vld0    = s0_cs & in_rng0;
    vld1    = s1_cs & in_rng1;

`ifdef MEM_ARB_HOLD_EN
    // hold_cnt of zero means no owner yet, so the plain round-robin rule applies
    keep = (hold_cnt_q != 3'd0) && (hold_cnt_q < HOLD_LIM);
    if (vld0 && vld1) win = keep ? rr_ptr_q : ~rr_ptr_q;
    else              win = vld1;
`else
    if (vld0 && vld1) win = ~rr_ptr_q;
    else              win = vld1;
`endif

    m_cs   = vld0 | vld1;
    m_we   = m_cs & (win ? s1_we : s0_we);
    m_addr = win ? s1_addr : s0_addr;
    m_byte = win ? s1_byte : s0_byte;
    m_di   = win ? s1_di   : s0_di;
    acc    = m_cs & ~m_busy;

    s0_busy = vld0 & (win ? 1'b1 : m_busy);
    s1_busy = vld1 & (win ? m_busy : 1'b1);
    s0_err  = err0_q;
    s1_err  = err1_q;

    // the returned beat passes straight through to its owner in the data cycle
    s0_do = (rd_vld_q && !rd_own_q) ? m_do : hold0_q;
    s1_do = (rd_vld_q &&  rd_own_q) ? m_do : hold1_q;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    rd_vld_d = 1'b0;
    rd_own_d = rd_own_q;
    hold0_d  = hold0_q;
    hold1_d  = hold1_q;
    err0_d   = s0_cs & ~in_rng0;
    err1_d   = s1_cs & ~in_rng1;

    if (acc) begin
      rr_ptr_d = win;
      if (!m_we) begin
        rd_vld_d = 1'b1;
        rd_own_d = win;
      end
    end

    if (rd_vld_q) begin
      if (rd_own_q) hold1_d = m_do;
      else          hold0_d = m_do;
    end
  end

`ifdef MEM_ARB_HOLD_EN
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (acc) begin
      if (win == rr_ptr_q && hold_cnt_q != 3'd0) begin
        if (hold_cnt_q != 3'd7) hold_cnt_d = hold_cnt_q + 3'd1;
      end else begin
        hold_cnt_d = 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hold_cnt_q <= 3'd0;
    else     hold_cnt_q <= hold_cnt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b1;
      rd_vld_q <= 1'b0;
      rd_own_q <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      hold0_q  <= 32'd0;
      hold1_q  <= 32'd0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rd_vld_q <= rd_vld_d;
      rd_own_q <= rd_own_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      hold0_q  <= hold0_d;
      hold1_q  <= hold1_d;
    end
  end

endmodule

// File: tb/tb_mem_rr_arb.sv
// Directed self-checking bench for mem_rr_arb: reset, single read, contention, stall,
// range errors and reset during a read data phase.
module tb_mem_rr_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        s0_cs, s0_we, s1_cs, s1_we;
   logic [31:0] s0_addr, s0_di, s1_addr, s1_di;
   logic [3:0]  s0_byte, s1_byte;
   logic [31:0] s0_do, s1_do;
   logic        s0_busy, s0_err, s1_busy, s1_err;
   logic        m_cs, m_we, m_busy;
   logic [31:0] m_addr, m_di, m_do;
   logic [3:0]  m_byte;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] exp0, exp1;
   logic        prevWin;
   logic        w;

   mem_rr_arb dut (
      .clk(clk), .rst(rst),
      .s0_cs(s0_cs), .s0_we(s0_we), .s0_addr(s0_addr), .s0_byte(s0_byte), .s0_di(s0_di),
      .s0_do(s0_do), .s0_busy(s0_busy), .s0_err(s0_err),
      .s1_cs(s1_cs), .s1_we(s1_we), .s1_addr(s1_addr), .s1_byte(s1_byte), .s1_di(s1_di),
      .s1_do(s1_do), .s1_busy(s1_busy), .s1_err(s1_err),
      .m_cs(m_cs), .m_we(m_we), .m_addr(m_addr), .m_byte(m_byte), .m_di(m_di),
      .m_do(m_do), .m_busy(m_busy)
   );

   // free-running 10-unit clock
   always #5 clk = ~clk;

   // Expected winner of the k-th back-to-back contention starting from reset
   function automatic logic expWinner(input int k);
`ifdef MEM_ARB_HOLD_EN
      return logic'((k / 4) % 2);
`else
      return logic'(k % 2);
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of requester and downstream inputs, then let combinational paths settle
   task automatic applyStimulus(input logic c0, input logic w0, input logic [31:0] a0,
                                input logic [31:0] d0, input logic c1, input logic w1,
                                input logic [31:0] a1, input logic [31:0] d1,
                                input logic mb, input logic [31:0] mdo);
      s0_cs = c0; s0_we = w0; s0_addr = a0; s0_di = d0;
      s1_cs = c1; s1_we = w1; s1_addr = a1; s1_di = d1;
      m_busy = mb; m_do = mdo;
      #2;
   endtask

   // One comparison: count it, and report any mismatch with its tag
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic idle(input logic [31:0] mdo);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, mdo);
   endtask

   // Main directed sequence
   initial begin
      rst = 1'b1;
      s0_byte = 4'hF; s1_byte = 4'h3;
      idle(32'd0);
      tick(); tick();
      rst = 1'b0;

      // reset state
      idle(32'd0);
      checkOutput("rst_m_cs",  32'(m_cs), 0);
      checkOutput("rst_s0_busy", 32'(s0_busy), 0);
      checkOutput("rst_s1_err", 32'(s1_err), 0);
      checkOutput("rst_s0_do", s0_do, 0);
      checkOutput("rst_s1_do", s1_do, 0);

      // single read by s0
      applyStimulus(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("rd_m_cs", 32'(m_cs), 1);
      checkOutput("rd_m_addr", m_addr, 32'h100);
      checkOutput("rd_m_we", 32'(m_we), 0);
      checkOutput("rd_m_byte", 32'(m_byte), 32'hF);
      checkOutput("rd_s0_busy", 32'(s0_busy), 0);
      tick();
      idle(32'hDEADBEEF);
      checkOutput("rd_data_m_cs", 32'(m_cs), 0);
      checkOutput("rd_data_s0_do", s0_do, 32'hDEADBEEF);
      checkOutput("rd_data_s1_do", s1_do, 0);
      tick();
      idle(32'h12345678);
      checkOutput("rd_held_s0_do", s0_do, 32'hDEADBEEF);

      // contention from a fresh reset; model tracks each requester's last data beat
      rst = 1'b1; tick(); rst = 1'b0;
      exp0 = 0; exp1 = 0; prevWin = 0;
      for (int k = 0; k < 7; k++) begin
         if (k < 6) applyStimulus(1, 0, 32'h200, 0, 1, 0, 32'h300, 0, 0, 32'hA000_0000 + k);
         else       idle(32'hA000_0000 + k);
         if (k > 0) begin
            if (prevWin) exp1 = 32'hA000_0000 + k;
            else         exp0 = 32'hA000_0000 + k;
         end
         checkOutput("cont_s0_do", s0_do, exp0);
         checkOutput("cont_s1_do", s1_do, exp1);
         if (k < 6) begin
            w = expWinner(k);
            checkOutput("cont_m_addr", m_addr, w ? 32'h300 : 32'h200);
            checkOutput("cont_s0_busy", 32'(s0_busy), 32'(w));
            checkOutput("cont_s1_busy", 32'(s1_busy), 32'(!w));
            prevWin = w;
         end
         tick();
      end

      // downstream stall on an s1 write
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 0, 1, 1, 32'h20, 32'h55AA55AA, (i < 3), 0);
         checkOutput("stall_m_cs", 32'(m_cs), 1);
         checkOutput("stall_m_we", 32'(m_we), 1);
         checkOutput("stall_m_addr", m_addr, 32'h20);
         checkOutput("stall_m_di", m_di, 32'h55AA55AA);
         checkOutput("stall_s1_busy", 32'(s1_busy), 32'(i < 3));
         tick();
      end
      applyStimulus(1, 1, 32'h24, 0, 1, 1, 32'h28, 0, 0, 0);
`ifdef MEM_ARB_HOLD_EN
      checkOutput("post_stall_m_addr", m_addr, 32'h28);
`else
      checkOutput("post_stall_m_addr", m_addr, 32'h24);
`endif
      checkOutput("post_stall_s1_do", s1_do, exp1);
      tick();

      // out-of-range s0 alongside a valid s1 read
      applyStimulus(1, 0, 32'h0002_0000, 0, 1, 0, 32'h40, 0, 0, 0);
      checkOutput("rng_m_cs", 32'(m_cs), 1);
      checkOutput("rng_m_addr", m_addr, 32'h40);
      checkOutput("rng_s0_busy", 32'(s0_busy), 0);
      checkOutput("rng_s1_busy", 32'(s1_busy), 0);
      checkOutput("rng_s0_err_early", 32'(s0_err), 0);
      tick();
      idle(32'hC0FFEE00);
      exp1 = 32'hC0FFEE00;
      checkOutput("rng_s0_err", 32'(s0_err), 1);
      checkOutput("rng_s1_err", 32'(s1_err), 0);
      checkOutput("rng_s1_do", s1_do, exp1);
      checkOutput("rng_s0_do", s0_do, exp0);
      tick();
      idle(0);
      checkOutput("rng_s0_err_pulse", 32'(s0_err), 0);

      // window edges: last in-range word vs first out-of-range byte
      applyStimulus(1, 0, 32'h0000_FFFC, 0, 1, 0, 32'h0001_0000, 0, 0, 0);
      checkOutput("edge_m_addr", m_addr, 32'h0000_FFFC);
      checkOutput("edge_s0_busy", 32'(s0_busy), 0);
      checkOutput("edge_s1_busy", 32'(s1_busy), 0);
      tick();
      idle(32'h0BADF00D);
      exp0 = 32'h0BADF00D;
      checkOutput("edge_s1_err", 32'(s1_err), 1);
      checkOutput("edge_s0_do", s0_do, exp0);
      checkOutput("edge_s1_do", s1_do, exp1);
      tick();

      // reset during the data cycle of an s0 read
      applyStimulus(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
      tick();
      rst = 1'b1;
      idle(32'h77);
      tick();
      rst = 1'b0;
      idle(32'h99);
      checkOutput("rstrd_s0_do", s0_do, 0);
      checkOutput("rstrd_s1_do", s1_do, 0);
      checkOutput("rstrd_s0_err", 32'(s0_err), 0);
      checkOutput("rstrd_m_cs", 32'(m_cs), 0);
      applyStimulus(1, 0, 32'h200, 0, 1, 0, 32'h300, 0, 0, 0);
      checkOutput("rstrd_first_win", m_addr, 32'h200);
      tick();

      // twelve back-to-back writes from both requesters after reset
      rst = 1'b1; tick(); rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1, 1, 32'h400, 0, 1, 1, 32'h500, 0, 0, 0);
         w = expWinner(k);
         checkOutput("pat_m_addr", m_addr, w ? 32'h500 : 32'h400);
         tick();
      end
      idle(0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_rr_arb.md
Name: mem_rr_arb

Overview:
- Two-requester round-robin arbiter that shares one memory-interface port (cs/we/addr/byte/di/do/busy) between two memory-interface masters, for example the instruction-fetch and data-access ports of the CPU, placed in front of a single SRAM or bridge port.
- Tracks the owner of each read data phase and routes the returned data back to that owner.
- Rejects accesses outside a configured address window with a one-cycle error pulse; such accesses never reach downstream.

Parameters:
ADDR_BASE  32'h0000_0000  window base address
ADDR_SIZE  32'h0001_0000  window size in bytes; 0 = full 4 GiB window
HOLD_MAX   4              max consecutive accepts kept by one requester (used only with MEM_ARB_HOLD_EN)

Ports:
clk      in   1   clock
rst      in   1   synchronous reset, active-high
s0_cs    in   1   requester 0 request
s0_we    in   1   requester 0 write enable
s0_addr  in   32  requester 0 byte address
s0_byte  in   4   requester 0 byte strobes
s0_di    in   32  requester 0 write data
s0_do    out  32  requester 0 read data
s0_busy  out  1   requester 0 stall
s0_err   out  1   requester 0 access error
s1_*     same set as s0_* for requester 1
m_cs     out  1   downstream request
m_we     out  1   downstream write enable
m_addr   out  32  downstream address
m_byte   out  4   downstream byte strobes
m_di     out  32  downstream write data
m_do     in   32  downstream read data, valid 1 cycle after accept
m_busy   in   1   downstream stall

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset state:
  - rr_ptr=1, so s0 wins the first contest.
  - rd_vld=0, rd_own=0, err0_q=err1_q=0, hold0_q=hold1_q=0.
  - Outputs follow combinationally: m_cs=0, s*_busy=0, s*_err=0, s*_do=0.
- Range check: in_rng_i = (ADDR_SIZE==0) | ((s_i_addr - ADDR_BASE) < ADDR_SIZE), using 32-bit unsigned wraparound subtraction.
- Valid request: vld_i = s_i_cs & in_rng_i.
- Arbitration (combinational, every cycle):
  - Only one requester valid: it wins.
  - Both valid: the winner is the requester that is not rr_ptr.
- Downstream forwarding:
  - m_cs = vld0 | vld1.
  - m_we/m_addr/m_byte/m_di are muxed from the winner.
  - When m_cs=0, m_we=0 and the other m_* outputs are don't-care.
- Accept: acc = m_cs & ~m_busy.
  - On acc: rr_ptr <= winner.
  - m_busy=1 leaves rr_ptr unchanged, and the grant may switch next cycle only if the requests change. Requesters must hold their request while busy.
- Busy:
  - Winner: s_busy = m_busy.
  - Valid loser: s_busy = 1.
  - Out-of-range request: s_busy = 0, completed locally.
  - cs=0: s_busy = 0.
- Read data phase:
  - On acc with ~m_we: rd_vld <= 1 and rd_own <= winner. Otherwise rd_vld <= 0.
  - In the cycle after acc, s{rd_own}_do = m_do (combinational pass-through) and hold{rd_own}_q <= m_do.
  - At all other times s_i_do = hold_i_q.
  - The data phase completes regardless of m_busy in that cycle. Back-to-back reads give 1 beat per cycle.
- Error:
  - s_i_cs & ~in_rng_i: err_i_q <= 1 for one cycle; s_i_err = err_i_q.
  - Erroring requester: no downstream access, no rr_ptr update, hold_i_q unchanged.
  - An error on one port does not affect the other port's arbitration.
- Writes have no data phase; s_do is unaffected.
- Simultaneous events:
  - Error on s0 with a valid s1 in the same cycle: s1 is granted.
  - Read data phase of s0 coincident with a new accept of s1: both proceed.
- rst asserted mid-transaction drops any pending rd_vld; the data beat is discarded and hold registers are cleared.

Optional Feature:
MEM_ARB_HOLD_EN:
- Defined:
  - A 3-bit counter hold_cnt counts consecutive accepts by the current rr_ptr owner.
  - While hold_cnt < HOLD_MAX and the owner is still valid, the owner keeps priority over the other requester.
  - When hold_cnt reaches HOLD_MAX, or the owner goes idle or switches, priority passes to the other requester and hold_cnt resets to 1 on the next accept.
  - Reset value: hold_cnt=0.
- Undefined: strict alternation as specified above; HOLD_MAX is unused.

Test Plan:
- Single read: s0 read at 0x100, m_busy=0, m_do=0xDEADBEEF one cycle later -> m_cs=1 for 1 cycle with m_addr=0x100; s0_do=0xDEADBEEF in the following cycle and held afterwards; s0_busy=0 throughout.
- Contention: s0 and s1 read continuously for 6 cycles -> accepts alternate s0,s1,s0,s1,s0,s1; the losing requester sees busy=1; each s_do returns only its own data.
- Downstream stall: s1 writes 0x55AA55AA to 0x20 with m_busy=1 for 3 cycles -> m_* held stable, s1_busy=1 for 3 cycles, accepted on cycle 4, rr_ptr=1 afterwards.
- Range error: s0 accesses 0x0002_0000 with defaults -> m_cs=0, s0_busy=0, s0_err=1 exactly one cycle later; s0_do unchanged; a concurrent s1 request is granted.
- Reset mid-read: accept s0 read, assert rst in the data cycle -> s0_do=0, s0_err=0, and the next contest is won by s0.
- With MEM_ARB_HOLD_EN and HOLD_MAX=4: both requesters continuously valid -> accept pattern s0×4, s1×4, s0×4.
